keypad_decimal_entry: RTL and testbench

//  Scans a 4x4 matrix keypad (Pmod KYPD layout) and turns debounced key presses into a signed decimal number.

---
 rtl/keypad_decimal_entry_pkg.sv | 32 +++
 rtl/keypad_decimal_entry_if.sv | 20 ++
 rtl/keypad_decimal_entry_scanner.sv | 108 ++++++++++
 rtl/keypad_decimal_entry.sv | 102 ++++++++++
 tb/tb_keypad_decimal_entry.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/keypad_decimal_entry_pkg.sv
// Shared key codes, scan table and value helpers
// for the keypad decimal entry block.
package keypad_decimal_entry_pkg;

    localparam logic [3:0] KEY_NEG   = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENTER = 4'hE;

    // Indexed by col*4 + row (row 0 at top).
    localparam logic [3:0] KEY_TABLE [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    function automatic logic [3:0] key_code(input logic [3:0] idx);
        return KEY_TABLE[idx];
    endfunction

    // Sign-magnitude to 11-bit two's complement; -0 folds to 0.
    function automatic logic [10:0] to_signed(
        input logic       neg,
        input logic [9:0] mag
    );
        logic [10:0] m;
        m = {1'b0, mag};
        return neg ? (~m + 11'd1) : m;
    endfunction

endpackage

// File: rtl/keypad_decimal_entry_if.sv
// Keypad wiring and value outputs of the entry block.
// master = entry block, slave = keypad/display side.
interface keypad_decimal_entry_if;
    logic [3:0]  i_rows;
    logic [3:0]  o_cols;
    logic [10:0] o_edit;
    logic [1:0]  o_digits;
    logic [10:0] o_data;
    logic        o_valid;

    modport master (
        input  i_rows,
        output o_cols, o_edit, o_digits, o_data, o_valid
    );

    modport slave (
        output i_rows,
        input  o_cols, o_edit, o_digits, o_data, o_valid
    );
endinterface

// File: rtl/keypad_decimal_entry_scanner.sv
// Row sync, column scan, frame debounce and arming;
// emits a one-cycle key event per accepted press.
module keypad_decimal_entry_scanner
    import keypad_decimal_entry_pkg::*;
#(
    parameter int I_CLK_FRQ = 100_000_000,
    parameter int SCAN_FRQ  = 1_000,
    parameter int DEBOUNCE  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_rows,
    output logic [3:0] o_cols,
    output logic [3:0] o_key,
    output logic       o_key_valid
);

    localparam int DIV = I_CLK_FRQ / SCAN_FRQ;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    rows_q1;
    logic [3:0]    rows_q2;
    logic [1:0]    col;
    logic [15:0]   acc;
    logic [15:0]   prev;
    logic [15:0]   cur_map;
    logic [3:0]    stable;
    logic [3:0]    stable_nxt;
    logic          armed;
    logic          onehot;
    logic          settled;
    logic [3:0]    idx;

    assign tick   = (div_cnt == DW'(DIV - 1));
    assign o_cols = ~(4'b0001 << col);

    // Scan-rate divider: one tick every DIV clocks.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) div_cnt <= '0;
        else          div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    // Two-flop synchronizer; idle rows read high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows_q1 <= 4'hF;
            rows_q2 <= 4'hF;
        end else begin
            rows_q1 <= i_rows;
            rows_q2 <= rows_q1;
        end
    end

    // Current frame map with this column merged, plus debounce terms.
    always_comb begin
        cur_map = acc;
        cur_map[{col, 2'b00} +: 4] = ~rows_q2;
        if (cur_map == prev)
            stable_nxt = (stable == 4'hF) ? stable : stable + 4'd1;
        else
            stable_nxt = '0;
        settled = (stable_nxt == 4'(DEBOUNCE));
        onehot  = (cur_map != '0) &&
                  ((cur_map & (cur_map - 16'd1)) == '0);
        idx = '0;
        for (int i = 0; i < 16; i++)
            if (cur_map[i]) idx = 4'(i);
    end

    // Column stepping, frame compare, arming and key event.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col         <= '0;
            acc         <= '0;
            prev        <= '0;
            stable      <= '0;
            armed       <= 1'b0;
            o_key       <= '0;
            o_key_valid <= 1'b0;
        end else begin
            o_key_valid <= 1'b0;
            if (tick) begin
                col <= col + 2'd1;
                if (col == 2'd3) begin
                    acc    <= '0;
                    prev   <= cur_map;
                    stable <= stable_nxt;
                    if (settled) begin
                        if (cur_map == '0) begin
                            armed <= 1'b1;
                        end else begin
                            armed <= 1'b0;
                            if (armed && onehot) begin
                                o_key_valid <= 1'b1;
                                o_key       <= key_code(idx);
                            end
                        end
                    end
                end else begin
                    acc <= cur_map;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_decimal_entry.sv
// Keypad to signed decimal entry: digit accumulation,
// sign toggle, backspace, clear and commit.
module keypad_decimal_entry
    import keypad_decimal_entry_pkg::*;
#(
    parameter int I_CLK_FRQ = 100_000_000,
    parameter int SCAN_FRQ  = 1_000,
    parameter int DEBOUNCE  = 4,
    parameter int DIGITS    = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    keypad_decimal_entry_if.master bus
);

    logic [3:0]  key;
    logic        key_valid;
    logic [9:0]  mag, mag_nxt;
    logic        neg, neg_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        commit;
    logic [13:0] prod;
    logic [10:0] edit_q, data_q;
    logic        valid_q;

    keypad_decimal_entry_scanner #(
        .I_CLK_FRQ (I_CLK_FRQ),
        .SCAN_FRQ  (SCAN_FRQ),
        .DEBOUNCE  (DEBOUNCE)
    ) u_scanner (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rows      (bus.i_rows),
        .o_cols      (bus.o_cols),
        .o_key       (key),
        .o_key_valid (key_valid)
    );

    // Next entry state for the current key event.
    always_comb begin
        mag_nxt = mag;
        neg_nxt = neg;
        cnt_nxt = cnt;
        commit  = 1'b0;
        prod    = {4'b0, mag} * 14'd10 + {10'b0, key};
        if (key_valid) begin
            unique case (1'b1)
                (key <= 4'd9): begin
                    if (cnt < 2'(DIGITS)) begin
                        mag_nxt = prod[9:0];
                        if (!(mag == '0 && key == 4'd0))
                            cnt_nxt = cnt + 2'd1;
                    end
                end
                (key == KEY_NEG): neg_nxt = ~neg;
                (key == KEY_BKSP): begin
                    if (cnt != '0) begin
                        mag_nxt = mag / 10'd10;
                        cnt_nxt = cnt - 2'd1;
                    end
                end
                (key == KEY_CLR): begin
                    mag_nxt = '0;
                    neg_nxt = 1'b0;
                    cnt_nxt = '0;
                end
                (key == KEY_ENTER): begin
                    commit  = 1'b1;
                    mag_nxt = '0;
                    neg_nxt = 1'b0;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    // Entry registers, edit view and commit output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mag     <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            edit_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mag     <= mag_nxt;
            neg     <= neg_nxt;
            cnt     <= cnt_nxt;
            edit_q  <= to_signed(neg_nxt, mag_nxt);
            valid_q <= commit;
            if (commit) data_q <= to_signed(neg, mag);
        end
    end

    assign bus.o_edit   = edit_q;
    assign bus.o_digits = cnt;
    assign bus.o_data   = data_q;
    assign bus.o_valid  = valid_q;

endmodule

// File: tb/tb_keypad_decimal_entry.sv
// Directed bench for keypad_decimal_entry with a
// column-driven keypad model.
module tb_keypad_decimal_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;
    int          passed = 0;
    int          total = 0;
    int          vcnt = 0;
    logic [10:0] last_data = '0;
    logic        found;

    keypad_decimal_entry_if bus ();

    keypad_decimal_entry #(
        .I_CLK_FRQ (1000),
        .SCAN_FRQ  (250),
        .DEBOUNCE  (2),
        .DIGITS    (3)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        bus.i_rows = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!bus.o_cols[c] && keys[c*4 + r]) bus.i_rows[r] = 1'b0;
    end

    // Commit monitor: counts cycles with o_valid high.
    always @(negedge clk) begin
        if (bus.o_valid) begin
            vcnt      = vcnt + 1;
            last_data = bus.o_data;
        end
    end

    function automatic int key_index(input logic [3:0] code);
        case (code)
            4'h1: return 0;   4'h4: return 1;
            4'h7: return 2;   4'h0: return 3;
            4'h2: return 4;   4'h5: return 5;
            4'h8: return 6;   4'hF: return 7;
            4'h3: return 8;   4'h6: return 9;
            4'h9: return 10;  4'hE: return 11;
            4'hA: return 12;  4'hB: return 13;
            4'hC: return 14;  default: return 15;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic frames(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code);
        keys = '0;
        keys[key_index(code)] = 1'b1;
        frames(6);
        keys = '0;
        frames(6);
    endtask

    initial begin
        // Key 1 held through reset.
        keys[key_index(4'h1)] = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cols", 32'(bus.o_cols), 32'hE);
        check("rst_edit", 32'(bus.o_edit), 32'h0);
        check("rst_digits", 32'(bus.o_digits), 32'h0);
        check("rst_data", 32'(bus.o_data), 32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        rst_n = 1'b1;
        frames(8);
        check("held_edit", 32'(bus.o_edit), 32'h0);
        check("held_digits", 32'(bus.o_digits), 32'h0);
        keys = '0;
        frames(6);

        // 1,2,3,E
        press(4'h1);
        check("e1_edit", 32'(bus.o_edit), 32'd1);
        check("e1_digits", 32'(bus.o_digits), 32'd1);
        press(4'h2);
        check("e12_edit", 32'(bus.o_edit), 32'd12);
        press(4'h3);
        check("e123_edit", 32'(bus.o_edit), 32'd123);
        check("e123_digits", 32'(bus.o_digits), 32'd3);
        check("pre_commit_cnt", 32'(vcnt), 32'd0);
        press(4'hE);
        check("c123_count", 32'(vcnt), 32'd1);
        check("c123_data", 32'(last_data), 32'd123);
        check("c123_edit", 32'(bus.o_edit), 32'd0);
        check("c123_digits", 32'(bus.o_digits), 32'd0);

        // 4,5,A,E -> -45
        press(4'h4);
        press(4'h5);
        check("e45_edit", 32'(bus.o_edit), 32'd45);
        press(4'hA);
        check("en45_edit", 32'(bus.o_edit), 32'h7D3);
        check("en45_digits", 32'(bus.o_digits), 32'd2);
        press(4'hE);
        check("cn45_count", 32'(vcnt), 32'd2);
        check("cn45_data", 32'(bus.o_data), 32'h7D3);

        // 4,5,A,A,E -> +45
        press(4'h4);
        press(4'h5);
        press(4'hA);
        press(4'hA);
        check("eaa_edit", 32'(bus.o_edit), 32'd45);
        press(4'hE);
        check("caa_count", 32'(vcnt), 32'd3);
        check("caa_data", 32'(bus.o_data), 32'd45);

        // 9,9,9,9 then B, C
        press(4'h9);
        press(4'h9);
        press(4'h9);
        press(4'h9);
        check("e999_edit", 32'(bus.o_edit), 32'd999);
        check("e999_digits", 32'(bus.o_digits), 32'd3);
        press(4'hB);
        check("bk_edit", 32'(bus.o_edit), 32'd99);
        check("bk_digits", 32'(bus.o_digits), 32'd2);
        press(4'hC);
        check("clr_edit", 32'(bus.o_edit), 32'd0);
        check("clr_digits", 32'(bus.o_digits), 32'd0);

        // Half-frame glitch on key 1.
        keys[key_index(4'h1)] = 1'b1;
        repeat (8) @(negedge clk);
        keys = '0;
        frames(6);
        check("glitch_edit", 32'(bus.o_edit), 32'd0);
        check("glitch_digits", 32'(bus.o_digits), 32'd0);

        // 1+2 together, then 2 alone.
        keys[key_index(4'h1)] = 1'b1;
        keys[key_index(4'h2)] = 1'b1;
        frames(6);
        keys = '0;
        frames(6);
        check("multi_edit", 32'(bus.o_edit), 32'd0);
        press(4'h2);
        check("after_multi_edit", 32'(bus.o_edit), 32'd2);
        press(4'hC);

        // Leading zero, then commit with nothing entered.
        press(4'h0);
        check("lz_digits", 32'(bus.o_digits), 32'd0);
        press(4'h5);
        check("lz5_edit", 32'(bus.o_edit), 32'd5);
        check("lz5_digits", 32'(bus.o_digits), 32'd1);
        press(4'hC);
        press(4'hE);
        check("c0_count", 32'(vcnt), 32'd4);
        check("c0_data", 32'(bus.o_data), 32'd0);

        // 7,8 then asynchronous reset mid-frame.
        press(4'h7);
        press(4'h8);
        check("e78_edit", 32'(bus.o_edit), 32'd78);
        keys[key_index(4'h9)] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.o_cols != 4'hE) found = 1'b1;
        end
        check("col_away", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_edit", 32'(bus.o_edit), 32'd0);
        check("arst_cols", 32'(bus.o_cols), 32'hE);
        check("arst_digits", 32'(bus.o_digits), 32'd0);
        keys = '0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        frames(4);
        check("arst_count", 32'(vcnt), 32'd4);
        check("arst_data", 32'(bus.o_data), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
